// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the core pipeline-stage registers: occupancy states and per-boundary payload widths.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_ONE   = ST_ONE,
    S_FULL  = ST_FULL
  } pipe_st_e;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned IF_ID_W    = 64;  // {pc, instr}
  localparam int unsigned ID_EX_W    = 128;
  localparam int unsigned EX_MEM_W   = 104;
  localparam int unsigned MEM_WB_W   = 70;  // {reg_write, rd, ld_data, alu_result}

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle around one pipeline-stage register: upstream (in_*) and downstream (out_*) sides.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  // master: the surrounding pipeline (feeds in_*, consumes out_*); slave: the stage register
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register with stall, flush and optional two-entry skid keeping in_ready registered.
// Latency 1 cycle; order preserved; flush drops held entries and any same-cycle input.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned          DATA_W     = DATA_W_DEF,
  parameter bit                   SKID_EN    = 1'b1,
  parameter logic [DATA_W-1:0]    RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  pipe_stage_reg_if.slave  bus,
  output logic [1:0]       occupancy
);

  pipe_st_e          st_q, st_nxt;
  logic [DATA_W-1:0] main_q, main_nxt;
  logic [DATA_W-1:0] skid_q, skid_nxt;
  logic              in_rdy;
  logic              out_vld;
  logic              in_xfer;
  logic              out_xfer;

  assign out_vld  = (st_q != S_EMPTY);
  assign in_xfer  = bus.in_valid && in_rdy;
  assign out_xfer = out_vld && bus.out_ready;

  always_comb begin
    st_nxt   = st_q;
    main_nxt = main_q;
    skid_nxt = skid_q;
    if (flush) begin
      st_nxt   = S_EMPTY;
      main_nxt = RESET_DATA;
      skid_nxt = RESET_DATA;
    end else begin
      unique case (st_q)
        S_EMPTY: begin
          if (in_xfer) begin
            st_nxt   = S_ONE;
            main_nxt = bus.in_data;
          end
        end
        S_ONE: begin
          // Without a skid, in_xfer implies out_xfer here, so FULL is never entered.
          if (in_xfer && out_xfer) begin
            main_nxt = bus.in_data;
          end else if (in_xfer) begin
            st_nxt   = S_FULL;
            skid_nxt = bus.in_data;
          end else if (out_xfer) begin
            st_nxt   = S_EMPTY;
          end
        end
        S_FULL: begin
          if (out_xfer) begin
            st_nxt   = S_ONE;
            main_nxt = skid_q;
          end
        end
        default: st_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= S_EMPTY;
      main_q <= RESET_DATA;
    end else begin
      st_q   <= st_nxt;
      main_q <= main_nxt;
    end
  end

  generate
    if (SKID_EN) begin : g_skid
      logic rdy_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          skid_q <= RESET_DATA;
          rdy_q  <= 1'b1;
        end else begin
          skid_q <= skid_nxt;
          rdy_q  <= (st_nxt != S_FULL);
        end
      end

      assign in_rdy = rdy_q;
    end else begin : g_noskid
      assign skid_q = RESET_DATA;
      assign in_rdy = !out_vld || bus.out_ready;
    end
  endgenerate

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_data  = main_q;
  assign occupancy     = st_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: skid instance (directed), no-skid instance (directed), 70-bit skid instance (random handshake).
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam logic [31:0] A_RST = 32'h0BAD_F00D;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic fl_a = 1'b0, fl_b = 1'b0, fl_c = 1'b0;
  logic [1:0] occ_a, occ_b, occ_c;

  int vec_cnt = 0;
  int err_cnt = 0;

  pipe_stage_reg_if #(.DATA_W(32)) a_if ();
  pipe_stage_reg_if #(.DATA_W(32)) b_if ();
  pipe_stage_reg_if #(.DATA_W(70)) c_if ();

  pipe_stage_reg #(.DATA_W(32), .SKID_EN(1'b1), .RESET_DATA(A_RST)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(fl_a), .bus(a_if), .occupancy(occ_a));
  pipe_stage_reg #(.DATA_W(32), .SKID_EN(1'b0), .RESET_DATA(32'h0)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(fl_b), .bus(b_if), .occupancy(occ_b));
  pipe_stage_reg #(.DATA_W(70), .SKID_EN(1'b1), .RESET_DATA(70'h0)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(fl_c), .bus(c_if), .occupancy(occ_c));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic [69:0] q_c[$];
  logic        c_acc = 1'b0;
  int          c_push = 0, c_pop = 0;

  // Transfers are decided at the next posedge; inputs are stable at the negedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_if.out_valid && a_if.out_ready) begin
        chk("a_unexpected_out", (q_a.size() != 0), 1'b1);
        if (q_a.size() != 0) chk("a_data", a_if.out_data, q_a.pop_front());
      end
      if (fl_a) q_a.delete();
      else if (a_if.in_valid && a_if.in_ready) q_a.push_back(a_if.in_data);

      if (b_if.out_valid && b_if.out_ready) begin
        chk("b_unexpected_out", (q_b.size() != 0), 1'b1);
        if (q_b.size() != 0) chk("b_data", b_if.out_data, q_b.pop_front());
      end
      if (fl_b) q_b.delete();
      else if (b_if.in_valid && b_if.in_ready) q_b.push_back(b_if.in_data);

      if (c_if.out_valid && c_if.out_ready) begin
        chk("c_unexpected_out", (q_c.size() != 0), 1'b1);
        if (q_c.size() != 0) chk("c_data", c_if.out_data, q_c.pop_front());
        c_pop++;
      end
      c_acc = c_if.in_valid && c_if.in_ready;
      if (fl_c) q_c.delete();
      else if (c_acc) begin
        q_c.push_back(c_if.in_data);
        c_push++;
      end
    end
  end

  initial begin
    int seq;
    a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.out_ready = 1'b0;
    c_if.in_valid = 1'b0; c_if.in_data = '0; c_if.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_a_ovld", a_if.out_valid, 1'b0);
    chk("rst_a_occ", occ_a, 2'd0);
    chk("rst_a_irdy", a_if.in_ready, 1'b1);
    chk("rst_a_data", a_if.out_data, A_RST);
    chk("rst_b_irdy", b_if.in_ready, 1'b1);
    @(negedge clk) rst_n = 1'b1;

    // Streaming 1,2,3 with out_ready held
    tick(); a_if.in_valid = 1'b1; a_if.in_data = 32'h1; a_if.out_ready = 1'b1;
    tick(); chk("str_ovld1", a_if.out_valid, 1'b1); chk("str_d1", a_if.out_data, 32'h1);
            chk("str_occ1", occ_a, 2'd1); a_if.in_data = 32'h2;
    tick(); chk("str_d2", a_if.out_data, 32'h2); chk("str_occ2", occ_a, 2'd1); a_if.in_data = 32'h3;
    tick(); chk("str_d3", a_if.out_data, 32'h3); chk("str_occ3", occ_a, 2'd1); a_if.in_valid = 1'b0;
    tick(); chk("str_empty_occ", occ_a, 2'd0); chk("str_empty_ovld", a_if.out_valid, 1'b0);

    // Stall: A held, B lands in skid, then release
    a_if.out_ready = 1'b0; a_if.in_valid = 1'b1; a_if.in_data = 32'hA;
    tick(); chk("stl_occ1", occ_a, 2'd1); chk("stl_irdy1", a_if.in_ready, 1'b1);
            chk("stl_dA", a_if.out_data, 32'hA); a_if.in_data = 32'hB;
    tick(); chk("stl_occ2", occ_a, 2'd2); chk("stl_irdy0", a_if.in_ready, 1'b0);
            chk("stl_dA_hold", a_if.out_data, 32'hA); a_if.in_data = 32'hE;
    tick(); chk("stl_occ2_hold", occ_a, 2'd2); chk("stl_dA_hold2", a_if.out_data, 32'hA);
            chk("stl_ovld_hold", a_if.out_valid, 1'b1);
            a_if.out_ready = 1'b1; a_if.in_valid = 1'b0;
    tick(); chk("stl_dB", a_if.out_data, 32'hB); chk("stl_rel_occ", occ_a, 2'd1);
            chk("stl_rel_irdy", a_if.in_ready, 1'b1);
    tick(); chk("stl_drain_occ", occ_a, 2'd0);

    // Flush while FULL, then flush while EMPTY with an acceptable input
    a_if.out_ready = 1'b0; a_if.in_valid = 1'b1; a_if.in_data = 32'h11;
    tick(); a_if.in_data = 32'h12;
    tick(); chk("fl_full_occ", occ_a, 2'd2);
            fl_a = 1'b1; a_if.in_data = 32'hC;
    tick(); chk("fl_ovld", a_if.out_valid, 1'b0); chk("fl_occ", occ_a, 2'd0);
            chk("fl_data", a_if.out_data, A_RST); chk("fl_irdy", a_if.in_ready, 1'b1);
            a_if.out_ready = 1'b1;
    tick(); chk("fl_drop_ovld", a_if.out_valid, 1'b0); chk("fl_drop_occ", occ_a, 2'd0);
            fl_a = 1'b0; a_if.in_data = 32'h13;
    tick(); chk("fl_pre_d13", a_if.out_data, 32'h13);
            fl_a = 1'b1; a_if.in_data = 32'hC;
    tick(); chk("fl_outx_ovld", a_if.out_valid, 1'b0);
            fl_a = 1'b0; a_if.in_valid = 1'b0;

    // No-skid instance: combinational in_ready
    b_if.in_valid = 1'b1; b_if.in_data = 32'h31; b_if.out_ready = 1'b0;
    tick(); chk("ns_ovld", b_if.out_valid, 1'b1); chk("ns_irdy0", b_if.in_ready, 1'b0);
            b_if.out_ready = 1'b1;
    #1;     chk("ns_irdy1_comb", b_if.in_ready, 1'b1); chk("ns_d31", b_if.out_data, 32'h31);
            b_if.in_data = 32'h32;
    tick(); chk("ns_d32", b_if.out_data, 32'h32); chk("ns_occ", occ_b, 2'd1);
            chk("ns_irdy_str", b_if.in_ready, 1'b1); b_if.in_data = 32'h33;
    tick(); chk("ns_d33", b_if.out_data, 32'h33); b_if.in_valid = 1'b0;
    tick(); chk("ns_empty_occ", occ_b, 2'd0);

    // 70-bit random handshake; a presented item is held until accepted
    seq = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (!c_if.in_valid || c_acc) begin
        if ($urandom_range(0, 3) != 0) begin
          c_if.in_valid = 1'b1;
          c_if.in_data  = {38'($urandom), 32'(seq)};
          seq++;
        end else begin
          c_if.in_valid = 1'b0;
        end
      end
      c_if.out_ready = ($urandom_range(0, 2) != 0);
    end
    tick(); c_if.in_valid = 1'b0; c_if.out_ready = 1'b1;
    repeat (5) tick();
    chk("c_drain_q", q_c.size(), 0);
    chk("c_count", c_pop, c_push);
    chk("c_occ", occ_c, 2'd0);

    // Async reset while FULL, no clock edge in between
    a_if.out_ready = 1'b0; a_if.in_valid = 1'b1; a_if.in_data = 32'h21;
    tick(); a_if.in_data = 32'h22;
    tick(); chk("rs_full_occ", occ_a, 2'd2); a_if.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rs_ovld", a_if.out_valid, 1'b0);
    chk("rs_occ", occ_a, 2'd0);
    chk("rs_irdy", a_if.in_ready, 1'b1);
    chk("rs_data", a_if.out_data, A_RST);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
